// File: rtl/neopx_pkg.sv
// Shared definitions for the NeoPixel receive path: register map indices,
// STATUS/CONTROL bit positions, pixel geometry and the decoder state encoding.
package neopx_pkg;

    // Register indices as seen on wb_adr_i[5:2]
    localparam logic [3:0] REG_STATUS  = 4'h0;   // byte offset 0x00
    localparam logic [3:0] REG_CONTROL = 4'h1;   // byte offset 0x04
    localparam logic [3:0] REG_CLEAR   = 4'h2;   // byte offset 0x08
    localparam logic [3:0] REG_PIXEL0  = 4'h8;   // byte offset 0x20, PIXEL[n] at 0x20 + 4n

    // STATUS bit positions
    localparam int STAT_FRAME_VALID = 0;
    localparam int STAT_BUSY        = 1;
    localparam int STAT_OVERFLOW    = 2;
    localparam int STAT_GLITCH      = 3;
    localparam int STAT_PARTIAL     = 4;
    localparam int STAT_COUNT_LSB   = 8;

    // CONTROL bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;

    // Pixel geometry
    localparam int PIX_BITS  = 24;
    localparam int PIX_CNT_W = 4;   // holds 0..8
    localparam int PIX_IDX_W = 3;   // addresses up to 8 slots

    typedef enum logic [1:0] {
        S_WAIT_GAP = 2'd0,
        S_IDLE     = 2'd1,
        S_HIGH     = 2'd2,
        S_LOW      = 2'd3
    } neopx_state_e;

endpackage

// File: rtl/neopx_decoder.sv
// WS2812 serial decoder: synchronizes the raw line, measures high/low pulse
// widths, assembles 24-bit pixel words MSB first and reports frame events.
module neopx_decoder
    import neopx_pkg::*;
#(
    parameter int NUM_PIXELS     = 8,
    parameter int BIT_THRESH_CYC = 43,
    parameter int MIN_HIGH_CYC   = 7,
    parameter int RESET_CYC      = 3600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 neopixel_in,
    output logic                 pix_we,
    output logic [PIX_IDX_W-1:0] pix_idx,
    output logic [PIX_BITS-1:0]  pix_data,
    output logic                 frame_end,
    output logic [PIX_CNT_W-1:0] frame_pix_cnt,
    output logic                 glitch,
    output logic                 overflow,
    output logic                 partial,
    output logic                 busy
);

    localparam int MAX_CYC = (RESET_CYC > BIT_THRESH_CYC) ? RESET_CYC : BIT_THRESH_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic                 sync1_r;
    logic                 sync2_r;
    neopx_state_e         state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic [PIX_BITS-1:0]  shift_r;
    logic [PIX_BITS-1:0]  shift_next_s;
    logic [4:0]           bit_cnt_r;
    logic [PIX_CNT_W-1:0] pix_cnt_r;
    logic                 bit_s;
    logic                 pix_we_r;
    logic [PIX_IDX_W-1:0] pix_idx_r;
    logic [PIX_BITS-1:0]  pix_data_r;
    logic                 frame_end_r;
    logic [PIX_CNT_W-1:0] frame_pix_cnt_r;
    logic                 glitch_r;
    logic                 overflow_r;
    logic                 partial_r;
    logic                 busy_r;

    // Two-flop synchronizer; the decoder only ever looks at sync2_r
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= neopixel_in;
            sync2_r <= sync1_r;
        end
    end

    // Saturating increment of the pulse-width counter and next shift value
    always_comb begin
        if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
        bit_s        = (cnt_r >= CNT_W'(BIT_THRESH_CYC));
        shift_next_s = {shift_r[PIX_BITS-2:0], bit_s};
    end

    // Decoder FSM. The state always tracks the line level, so a high sample in
    // IDLE/LOW is a rising edge and a low sample in HIGH is a falling edge.
    // The counter includes the sample that caused the transition, so on a
    // falling edge cnt_r equals the number of high samples in the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= S_WAIT_GAP;
            cnt_r           <= '0;
            shift_r         <= '0;
            bit_cnt_r       <= 5'd0;
            pix_cnt_r       <= '0;
            pix_we_r        <= 1'b0;
            pix_idx_r       <= '0;
            pix_data_r      <= '0;
            frame_end_r     <= 1'b0;
            frame_pix_cnt_r <= '0;
            glitch_r        <= 1'b0;
            overflow_r      <= 1'b0;
            partial_r       <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            pix_we_r    <= 1'b0;
            frame_end_r <= 1'b0;
            glitch_r    <= 1'b0;
            overflow_r  <= 1'b0;
            partial_r   <= 1'b0;
            if (!enable) begin
                // Disabled or aborted: forget the frame, keep the buffer
                state_r <= S_WAIT_GAP;
                cnt_r   <= '0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    S_WAIT_GAP: begin
                        if (sync2_r) begin
                            cnt_r <= '0;
                        end else if (cnt_inc_s == CNT_W'(RESET_CYC)) begin
                            state_r <= S_IDLE;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    S_IDLE: begin
                        if (sync2_r) begin
                            state_r   <= S_HIGH;
                            cnt_r     <= CNT_W'(1);
                            busy_r    <= 1'b1;
                            pix_cnt_r <= '0;
                            bit_cnt_r <= 5'd0;
                        end
                    end
                    S_HIGH: begin
                        if (sync2_r) begin
                            cnt_r <= cnt_inc_s;
                        end else if (cnt_r < CNT_W'(MIN_HIGH_CYC)) begin
                            glitch_r <= 1'b1;
                            busy_r   <= 1'b0;
                            state_r  <= S_WAIT_GAP;
                            cnt_r    <= '0;
                        end else begin
                            shift_r <= shift_next_s;
                            state_r <= S_LOW;
                            cnt_r   <= CNT_W'(1);
                            if (bit_cnt_r == 5'd23) begin
                                bit_cnt_r <= 5'd0;
                                if (pix_cnt_r < PIX_CNT_W'(NUM_PIXELS)) begin
                                    pix_we_r   <= 1'b1;
                                    pix_idx_r  <= pix_cnt_r[PIX_IDX_W-1:0];
                                    pix_data_r <= shift_next_s;
                                    pix_cnt_r  <= pix_cnt_r + PIX_CNT_W'(1);
                                end else begin
                                    overflow_r <= 1'b1;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    S_LOW: begin
                        if (sync2_r) begin
                            state_r <= S_HIGH;
                            cnt_r   <= CNT_W'(1);
                        end else if (cnt_inc_s == CNT_W'(RESET_CYC)) begin
                            frame_end_r     <= 1'b1;
                            frame_pix_cnt_r <= pix_cnt_r;
                            partial_r       <= (bit_cnt_r != 5'd0);
                            busy_r          <= 1'b0;
                            state_r         <= S_IDLE;
                            cnt_r           <= '0;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                    default: begin
                        state_r <= S_WAIT_GAP;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pix_we        = pix_we_r;
    assign pix_idx       = pix_idx_r;
    assign pix_data      = pix_data_r;
    assign frame_end     = frame_end_r;
    assign frame_pix_cnt = frame_pix_cnt_r;
    assign glitch        = glitch_r;
    assign overflow      = overflow_r;
    assign partial       = partial_r;
    assign busy          = busy_r;

endmodule

// File: rtl/wb_neopx_rx.sv
// Wishbone slave wrapping the WS2812 decoder: STATUS/CONTROL/CLEAR registers,
// a live pixel buffer and a frame-received interrupt.
module wb_neopx_rx
    import neopx_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PIXELS     = 8,
    parameter int BIT_THRESH_CYC = 43,
    parameter int MIN_HIGH_CYC   = 7,
    parameter int RESET_CYC      = 3600
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_stall_o,
    input  logic                  neopixel_in,
    output logic                  irq_o
);

    logic                  ack_r;
    logic [DATA_WIDTH-1:0] dat_r;
    logic                  irq_r;
    logic                  enable_r;
    logic                  irq_en_r;
    logic                  frame_valid_r;
    logic                  overflow_r;
    logic                  glitch_r;
    logic                  partial_r;
    logic [PIX_CNT_W-1:0]  pixel_count_r;
    logic [PIX_BITS-1:0]   pix_mem [0:NUM_PIXELS-1];

    logic                  req_s;
    logic                  wr_s;
    logic [3:0]            reg_idx_s;
    logic                  ctrl_wr_s;
    logic [4:0]            clr_mask_s;
    logic [DATA_WIDTH-1:0] rd_s;
    logic                  unused_s;

    logic                  dec_pix_we_s;
    logic [PIX_IDX_W-1:0]  dec_pix_idx_s;
    logic [PIX_BITS-1:0]   dec_pix_data_s;
    logic                  dec_frame_end_s;
    logic [PIX_CNT_W-1:0]  dec_frame_cnt_s;
    logic                  dec_glitch_s;
    logic                  dec_overflow_s;
    logic                  dec_partial_s;
    logic                  dec_busy_s;

    neopx_decoder #(
        .NUM_PIXELS     (NUM_PIXELS),
        .BIT_THRESH_CYC (BIT_THRESH_CYC),
        .MIN_HIGH_CYC   (MIN_HIGH_CYC),
        .RESET_CYC      (RESET_CYC)
    ) u_decoder (
        .clk           (wb_clk_i),
        .rst           (wb_rst_i),
        .enable        (enable_r),
        .neopixel_in   (neopixel_in),
        .pix_we        (dec_pix_we_s),
        .pix_idx       (dec_pix_idx_s),
        .pix_data      (dec_pix_data_s),
        .frame_end     (dec_frame_end_s),
        .frame_pix_cnt (dec_frame_cnt_s),
        .glitch        (dec_glitch_s),
        .overflow      (dec_overflow_s),
        .partial       (dec_partial_s),
        .busy          (dec_busy_s)
    );

    assign unused_s = ^{wb_adr_i[ADDR_WIDTH-1:6], wb_adr_i[1:0],
                        wb_dat_i[DATA_WIDTH-1:5], wb_sel_i[3:1]};

    // Bus request decode; only byte lane 0 carries writable bits
    always_comb begin
        req_s     = wb_cyc_i & wb_stb_i & ~ack_r;
        wr_s      = req_s & wb_we_i & wb_sel_i[0];
        reg_idx_s = wb_adr_i[5:2];
        ctrl_wr_s = wr_s & (reg_idx_s == REG_CONTROL);
        if (wr_s && (reg_idx_s == REG_CLEAR)) begin
            clr_mask_s = wb_dat_i[4:0];
        end else begin
            clr_mask_s = 5'b0_0000;
        end
    end

    // Read multiplexer; unmapped addresses and empty pixel slots read as zero
    always_comb begin
        rd_s = '0;
        case (reg_idx_s)
            REG_STATUS: begin
                rd_s[STAT_FRAME_VALID] = frame_valid_r;
                rd_s[STAT_BUSY]        = dec_busy_s;
                rd_s[STAT_OVERFLOW]    = overflow_r;
                rd_s[STAT_GLITCH]      = glitch_r;
                rd_s[STAT_PARTIAL]     = partial_r;
                rd_s[STAT_COUNT_LSB +: PIX_CNT_W] = pixel_count_r;
            end
            REG_CONTROL: begin
                rd_s[CTRL_ENABLE] = enable_r;
                rd_s[CTRL_IRQ_EN] = irq_en_r;
            end
            default: begin
                if ((reg_idx_s >= REG_PIXEL0) && ({1'b0, reg_idx_s[2:0]} < 4'(NUM_PIXELS))) begin
                    rd_s[PIX_BITS-1:0] = pix_mem[reg_idx_s[2:0]];
                end else begin
                    rd_s = '0;
                end
            end
        endcase
    end

    // Single-cycle acknowledge with read data registered alongside it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_r <= 1'b0;
            dat_r <= '0;
        end else begin
            ack_r <= req_s;
            dat_r <= (req_s && !wb_we_i) ? rd_s : '0;
        end
    end

    // CONTROL register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            enable_r <= 1'b0;
            irq_en_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            enable_r <= wb_dat_i[CTRL_ENABLE];
            irq_en_r <= wb_dat_i[CTRL_IRQ_EN];
        end
    end

    // Sticky STATUS flags; a decoder event in the same cycle as CLEAR wins
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            frame_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
            glitch_r      <= 1'b0;
            partial_r     <= 1'b0;
            pixel_count_r <= '0;
        end else begin
            frame_valid_r <= dec_frame_end_s | (frame_valid_r & ~clr_mask_s[STAT_FRAME_VALID]);
            overflow_r    <= dec_overflow_s  | (overflow_r    & ~clr_mask_s[STAT_OVERFLOW]);
            glitch_r      <= dec_glitch_s    | (glitch_r      & ~clr_mask_s[STAT_GLITCH]);
            partial_r     <= dec_partial_s   | (partial_r     & ~clr_mask_s[STAT_PARTIAL]);
            if (dec_frame_end_s) begin
                pixel_count_r <= dec_frame_cnt_s;
            end
        end
    end

    // Frame-received interrupt
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= frame_valid_r & irq_en_r;
        end
    end

    // Pixel buffer, written live by the decoder and deliberately not reset
    always_ff @(posedge wb_clk_i) begin
        if (dec_pix_we_s) begin
            pix_mem[dec_pix_idx_s] <= dec_pix_data_s;
        end
    end

    assign wb_ack_o   = ack_r;
    assign wb_dat_o   = dat_r;
    assign wb_stall_o = 1'b0;
    assign irq_o      = irq_r;

endmodule

// File: tb/tb_wb_neopx_rx.sv
// Directed self-checking bench for wb_neopx_rx.
module tb_wb_neopx_rx;

    localparam int T0H  = 29;
    localparam int T1H  = 58;
    localparam int TBIT = 90;

    localparam logic [31:0] A_STATUS  = 32'h0000_0000;
    localparam logic [31:0] A_CONTROL = 32'h0000_0004;
    localparam logic [31:0] A_CLEAR   = 32'h0000_0008;
    localparam logic [31:0] A_UNMAP   = 32'h0000_000C;
    localparam logic [31:0] A_PIX0    = 32'h0000_0020;
    localparam logic [31:0] A_PIX1    = 32'h0000_0024;
    localparam logic [31:0] A_PIX7    = 32'h0000_003C;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_stall_o;
    logic        neopixel_in;
    logic        irq_o;

    int n_checks = 0;
    int n_pass   = 0;

    wb_neopx_rx dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_stb_i    (wb_stb_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .wb_stall_o  (wb_stall_o),
        .neopixel_in (neopixel_in),
        .irq_o       (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        int n;
        @(posedge wb_clk_i); #1;
        wb_adr_i = adr; wb_dat_i = dat; wb_we_i = 1'b1; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (!wb_ack_o && n < 10);
        check("wr_ack", {31'd0, wb_ack_o}, 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        int n;
        @(posedge wb_clk_i); #1;
        wb_adr_i = adr; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (!wb_ack_o && n < 10);
        check("rd_ack", {31'd0, wb_ack_o}, 32'd1);
        dat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic px_low(input int n);
        neopixel_in = 1'b0;
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic px_bit(input logic b);
        int h;
        h = b ? T1H : T0H;
        neopixel_in = 1'b1;
        repeat (h) @(negedge wb_clk_i);
        neopixel_in = 1'b0;
        repeat (TBIT - h) @(negedge wb_clk_i);
    endtask

    task automatic px_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) begin
            px_bit(w[i]);
        end
    endtask

    task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(adr, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [23:0] w;
        wb_rst_i = 1'b1;
        wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
        wb_stb_i = 1'b0;  wb_cyc_i = 1'b0;  neopixel_in = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("stall", {31'd0, wb_stall_o}, 32'd0);
        wb_rst_i = 1'b0;
        rd_check("rst_status", A_STATUS, 32'h0000_0000);
        rd_check("rst_control", A_CONTROL, 32'h0000_0000);

        // Basic two-pixel frame, with busy observed mid-frame
        wb_write(A_CONTROL, 32'h1);
        px_low(3700);
        fork
            begin
                px_word(24'hFF0000);
                px_word(24'h00A55A);
            end
            begin
                repeat (600) @(posedge wb_clk_i);
                rd_check("busy_mid", A_STATUS, 32'h0000_0002);
            end
        join
        px_low(4000);
        rd_check("f1_status", A_STATUS, 32'h0000_0201);
        rd_check("f1_pix0", A_PIX0, 32'h00FF_0000);
        rd_check("f1_pix1", A_PIX1, 32'h0000_A55A);
        check("f1_irq_off", {31'd0, irq_o}, 32'd0);

        // Unmapped and write-only addresses read zero; stray writes ignored
        wb_write(A_UNMAP, 32'hFFFF_FFFF);
        rd_check("unmap_rd", A_UNMAP, 32'h0000_0000);
        rd_check("clear_rd", A_CLEAR, 32'h0000_0000);
        rd_check("ctrl_keep", A_CONTROL, 32'h0000_0001);

        // Interrupt path
        wb_write(A_CLEAR, 32'h1F);
        rd_check("clr_status", A_STATUS, 32'h0000_0200);
        wb_write(A_CONTROL, 32'h3);
        check("irq_pre", {31'd0, irq_o}, 32'd0);
        px_word(24'hFF0000);
        px_word(24'h00A55A);
        px_low(4000);
        check("irq_rise", {31'd0, irq_o}, 32'd1);
        rd_check("f2_status", A_STATUS, 32'h0000_0201);
        wb_write(A_CLEAR, 32'h1);
        check("irq_hold", {31'd0, irq_o}, 32'd1);
        @(posedge wb_clk_i); #1;
        check("irq_fall", {31'd0, irq_o}, 32'd0);

        // Overflow: nine pixels into an eight-slot buffer
        wb_write(A_CONTROL, 32'h1);
        wb_write(A_CLEAR, 32'h1F);
        w = 24'h111111;
        for (int i = 0; i < 9; i++) begin
            px_word(w);
            w = w + 24'h111111;
        end
        px_low(4000);
        rd_check("ovf_status", A_STATUS, 32'h0000_0805);
        rd_check("ovf_pix0", A_PIX0, 32'h0011_1111);
        rd_check("ovf_pix7", A_PIX7, 32'h0088_8888);

        // Partial: one pixel plus five bits
        wb_write(A_CLEAR, 32'h1F);
        px_word(24'h123456);
        px_bit(1'b1); px_bit(1'b0); px_bit(1'b1); px_bit(1'b1); px_bit(1'b0);
        px_low(4000);
        rd_check("part_status", A_STATUS, 32'h0000_0111);
        rd_check("part_pix0", A_PIX0, 32'h0012_3456);

        // Glitch mid-frame, then a clean frame
        wb_write(A_CLEAR, 32'h1F);
        px_word(24'hABCDEF);
        px_bit(1'b1); px_bit(1'b1);
        neopixel_in = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        px_low(4000);
        rd_check("glt_status", A_STATUS, 32'h0000_0108);
        rd_check("glt_pix0", A_PIX0, 32'h00AB_CDEF);
        px_word(24'hC0FFEE);
        px_word(24'h0F1E2D);
        px_low(4000);
        rd_check("glt_clean_status", A_STATUS, 32'h0000_0209);
        rd_check("glt_clean_pix0", A_PIX0, 32'h00C0_FFEE);
        rd_check("glt_clean_pix1", A_PIX1, 32'h000F_1E2D);

        // Asynchronous reset in the middle of a high pulse
        wb_write(A_CONTROL, 32'h3);
        @(posedge wb_clk_i); #1;
        check("irq_before_rst", {31'd0, irq_o}, 32'd1);
        @(negedge wb_clk_i);
        px_bit(1'b1); px_bit(1'b0); px_bit(1'b1);
        neopixel_in = 1'b1;
        repeat (20) @(negedge wb_clk_i);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("arst_irq", {31'd0, irq_o}, 32'd0);
        check("arst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("arst_dat", wb_dat_o, 32'd0);
        neopixel_in = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        rd_check("arst_status", A_STATUS, 32'h0000_0000);
        rd_check("arst_control", A_CONTROL, 32'h0000_0000);
        wb_write(A_CONTROL, 32'h1);
        px_word(24'h777777);
        px_low(4000);
        rd_check("nogap_status", A_STATUS, 32'h0000_0000);
        px_word(24'h3C3C3C);
        px_low(4000);
        rd_check("post_rst_status", A_STATUS, 32'h0000_0101);
        rd_check("post_rst_pix0", A_PIX0, 32'h003C_3C3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
